// File: rtl/fadd_pkg.sv
// Shared float-adder types: FSM state encoding, IEEE-754 single field layout and the quiet-NaN
// that is returned when the adder times out.
package fadd_pkg;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;

  typedef struct packed {
    logic [SIGN_W-1:0] sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;

  localparam fp32_t QNAN = '{sign: 1'b0, exp: 8'hff, mant: 23'h400000};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
  } opnd_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker: first set bit of req scanning upward from ptr with wrap-around.
// Purely combinational, zero latency; no backpressure of its own.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          found,
  output logic [PW-1:0] idx
);

  logic [PW-1:0] cand;

  // Scan from the farthest offset down so the one nearest ptr is the last (winning) assignment.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = PW'((int'(ptr) + k) % N);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fadd_share_arbiter.sv
// Shares one start/done float adder among NREQ clients, round-robin, one op in flight, with watchdog.
// Latency L+2 cycles from req_ready to resp_valid; clients are held off via req_ready until IDLE.
module fadd_share_arbiter
  import fadd_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [32*NREQ-1:0] req_x,
  input  logic [32*NREQ-1:0] req_y,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   resp_valid,
  output logic [31:0]       resp_z,
  output logic              resp_err,
  output logic              add_valid,
  output logic [31:0]       add_x,
  output logic [31:0]       add_y,
  input  logic              add_done,
  input  logic [31:0]       add_z
);

  localparam int PW = $clog2(NREQ);

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] grant;
  logic [TW-1:0] timer;
  logic          pick_found;
  logic [PW-1:0] pick_idx;
  opnd_t         ops [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      ops[i] = '{x: req_x[32*i +: 32], y: req_y[32*i +: 32]};
    end
  end

  rr_pick #(
    .N  (NREQ),
    .PW (PW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    req_ready = '0;
    if (state == IDLE && pick_found) req_ready[pick_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant      <= '0;
      timer      <= '0;
      resp_valid <= '0;
      resp_z     <= '0;
      resp_err   <= 1'b0;
      add_valid  <= 1'b0;
      add_x      <= '0;
      add_y      <= '0;
    end else begin
      add_valid  <= 1'b0;
      resp_valid <= '0;
      case (state)
        IDLE: begin
          // add_valid is raised on entry so the start pulse coincides with the ISSUE cycle.
          if (pick_found) begin
            add_x     <= ops[pick_idx].x;
            add_y     <= ops[pick_idx].y;
            grant     <= pick_idx;
            add_valid <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A done arriving on the last watchdog cycle still delivers the real sum.
          if (add_done) begin
            resp_z            <= add_z;
            resp_err          <= 1'b0;
            resp_valid[grant] <= 1'b1;
            state             <= RESP;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            resp_z            <= QNAN;
            resp_err          <= 1'b1;
            resp_valid[grant] <= 1'b1;
            state             <= RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP: begin
          rr_ptr <= (grant == PW'(NREQ - 1)) ? '0 : grant + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fadd_share_arbiter.sv
// Directed bench for fadd_share_arbiter: a vector table of single operations plus
// hand sequences for round-robin order, spurious done and reset during an operation.
module tb_fadd_share_arbiter;

  typedef struct {
    int          r;
    logic [31:0] x;
    logic [31:0] y;
    int          lat;
    bit          never;
    logic [31:0] z;
    logic [31:0] ez;
    bit          eerr;
    int          elat;
  } tvec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [127:0] req_x = '0;
  logic [127:0] req_y = '0;
  logic [3:0]   req_ready;
  logic [3:0]   resp_valid;
  logic [31:0]  resp_z;
  logic         resp_err;
  logic         add_valid;
  logic [31:0]  add_x;
  logic [31:0]  add_y;
  logic         add_done = 1'b0;
  logic [31:0]  add_z = '0;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int resp_cnt = 0;
  int exp_resp = 0;

  int          model_L = 1;
  bit          model_never = 1'b0;
  bit          xor_mode = 1'b0;
  logic [31:0] model_z = '0;
  int          spur_at = -1;
  int          cnt = 0;
  bit          busy = 1'b0;

  tvec_t       tv [7];
  int          order [6];
  logic [31:0] ox [4];
  logic [31:0] oy [4];

  fadd_share_arbiter #(.NREQ(4), .TIMEOUT(64), .TW(7)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_z     (resp_z),
    .resp_err   (resp_err),
    .add_valid  (add_valid),
    .add_x      (add_x),
    .add_y      (add_y),
    .add_done   (add_done),
    .add_z      (add_z)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && resp_valid != 4'b0) resp_cnt++;
  end

  // Adder model: done L cycles after the start pulse it sees; can also inject a stray done.
  always @(negedge clk) begin
    add_done = 1'b0;
    if (rst) begin
      busy = 1'b0;
      cnt  = 0;
    end else begin
      if (busy) begin
        cnt--;
        if (cnt == 0) begin
          add_done = 1'b1;
          add_z    = xor_mode ? (add_x ^ add_y) : model_z;
          busy     = 1'b0;
        end
      end
      if (add_valid && !model_never) begin
        busy = 1'b1;
        cnt  = model_L;
      end
      if (cyc == spur_at) begin
        add_done = 1'b1;
        add_z    = 32'hdeadbeef;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready();
    #1;
    for (int t = 0; t < 100 && req_ready == 4'b0; t++) nxt();
  endtask

  task automatic wait_resp();
    for (int t = 0; t < 200; t++) begin
      nxt();
      if (resp_valid != 4'b0) break;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    repeat (3) nxt();
    rst = 1'b0;
  endtask

  task automatic do_one(input tvec_t v, input string nm);
    int  rdy_c;
    int  nv;
    bit  stable;
    model_L     = v.lat;
    model_never = v.never;
    model_z     = v.z;
    xor_mode    = 1'b0;
    req_valid[v.r] = 1'b1;
    req_x[32*v.r +: 32] = v.x;
    req_y[32*v.r +: 32] = v.y;
    wait_ready();
    chk({nm, "_ready"}, 32'(req_ready), 32'(1) << v.r);
    rdy_c = cyc;
    nxt();
    // Operands change after capture; the adder side must keep the captured pair.
    req_valid[v.r] = 1'b0;
    req_x[32*v.r +: 32] = ~v.x;
    req_y[32*v.r +: 32] = ~v.y;
    chk({nm, "_addvalid"}, 32'(add_valid), 32'd1);
    chk({nm, "_addx"}, add_x, v.x);
    chk({nm, "_addy"}, add_y, v.y);
    nv = 0;
    stable = 1'b1;
    for (int t = 0; t < 200; t++) begin
      nxt();
      if (add_valid) nv++;
      if (add_x !== v.x || add_y !== v.y) stable = 1'b0;
      if (resp_valid != 4'b0) break;
    end
    exp_resp++;
    chk({nm, "_latency"}, 32'(cyc - rdy_c), 32'(v.elat));
    chk({nm, "_respvalid"}, 32'(resp_valid), 32'(1) << v.r);
    chk({nm, "_respz"}, resp_z, v.ez);
    chk({nm, "_resperr"}, 32'(resp_err), 32'(v.eerr));
    chk({nm, "_stable"}, 32'(stable), 32'd1);
    chk({nm, "_single_start"}, 32'(nv), 32'd0);
    nxt();
    chk({nm, "_resp_pulse"}, 32'(resp_valid), 32'd0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({nm, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({nm, "_resp_z"}, resp_z, 32'd0);
    chk({nm, "_resp_err"}, 32'(resp_err), 32'd0);
    chk({nm, "_add_valid"}, 32'(add_valid), 32'd0);
    chk({nm, "_add_x"}, add_x, 32'd0);
    chk({nm, "_add_y"}, add_y, 32'd0);
  endtask

  initial begin
    tvec_t v;
    int    g;
    //          r  x             y             L   never z             ez            err elat
    tv[0] = '{0, 32'h3f800000, 32'h40000000, 5,  1'b0, 32'h40400000, 32'h40400000, 1'b0, 7};
    tv[1] = '{1, 32'h40400000, 32'h40800000, 1,  1'b0, 32'h40e00000, 32'h40e00000, 1'b0, 3};
    tv[2] = '{2, 32'h3f800000, 32'h3f800000, 5,  1'b1, 32'h12345678, 32'h7fc00000, 1'b1, 66};
    tv[3] = '{3, 32'h3f800000, 32'h3f800000, 3,  1'b0, 32'h40000000, 32'h40000000, 1'b0, 5};
    tv[4] = '{0, 32'h40a00000, 32'h40a00000, 64, 1'b0, 32'h41200000, 32'h41200000, 1'b0, 66};
    tv[5] = '{1, 32'h41000000, 32'h3f800000, 65, 1'b0, 32'h41100000, 32'h7fc00000, 1'b1, 66};
    tv[6] = '{2, 32'hc0000000, 32'h40000000, 2,  1'b0, 32'h00000000, 32'h00000000, 1'b0, 4};
    order = '{0, 1, 2, 3, 1, 3};

    do_reset();
    chk_zero("reset");

    for (int i = 0; i < 7; i++) do_one(tv[i], $sformatf("row%0d", i));

    // All four requesting at once right after reset, then 1 and 3 again after grant 3.
    do_reset();
    xor_mode    = 1'b1;
    model_never = 1'b0;
    model_L     = 2;
    for (int i = 0; i < 4; i++) begin
      ox[i] = 32'h00000010 + 32'(i);
      oy[i] = 32'h01000000 << i;
      req_x[32*i +: 32] = ox[i];
      req_y[32*i +: 32] = oy[i];
    end
    req_valid = 4'hf;
    for (int k = 0; k < 6; k++) begin
      wait_ready();
      chk($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(1) << order[k]);
      g = order[k];
      nxt();
      req_valid[g] = 1'b0;
      if (k == 3) begin
        req_valid[1] = 1'b1;
        req_valid[3] = 1'b1;
      end
      wait_resp();
      exp_resp++;
      chk($sformatf("rr_resp%0d", k), 32'(resp_valid), 32'(1) << g);
      chk($sformatf("rr_z%0d", k), resp_z, ox[g] ^ oy[g]);
      nxt();
    end
    xor_mode = 1'b0;

    // Stray done while idle must not produce a response or start anything.
    spur_at = cyc + 1;
    g = 0;
    repeat (5) begin
      nxt();
      if (add_valid || resp_valid != 4'b0) g++;
    end
    spur_at = -1;
    chk("spurious_quiet", 32'(g), 32'd0);
    chk("spurious_count", 32'(resp_cnt), 32'(exp_resp));

    // Leave rr_ptr at 2, start a never-finishing op on 2, then reset in WAIT.
    do_reset();
    v = '{1, 32'h3f800000, 32'h3f800000, 2, 1'b0, 32'h40000000, 32'h40000000, 1'b0, 4};
    do_one(v, "pre_rst");
    model_never = 1'b1;
    req_x[64 +: 32] = 32'h40a00000;
    req_y[64 +: 32] = 32'h40a00000;
    req_valid[2] = 1'b1;
    wait_ready();
    chk("inflight_grant", 32'(req_ready), 32'h4);
    nxt();
    req_valid[2] = 1'b0;
    repeat (5) nxt();
    rst = 1'b1;
    nxt();
    chk_zero("midrst");
    rst = 1'b0;
    model_never = 1'b0;
    model_L = 2;
    model_z = 32'h3f000000;
    req_x[31:0]   = 32'h3e800000;
    req_y[31:0]   = 32'h3e800000;
    req_x[96 +: 32] = 32'h11111111;
    req_y[96 +: 32] = 32'h22222222;
    req_valid = 4'b1001;
    #1;
    chk("rst_ptr_grant", 32'(req_ready), 32'h1);
    nxt();
    req_valid = 4'b0;
    chk("post_rst_addx", add_x, 32'h3e800000);
    wait_resp();
    exp_resp++;
    chk("post_rst_resp", 32'(resp_valid), 32'h1);
    chk("post_rst_z", resp_z, 32'h3f000000);
    repeat (80) nxt();
    chk("total_resp", 32'(resp_cnt), 32'(exp_resp));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
